// File: rtl/fsm_transit_driver_if.sv
// Command and transit handshake bundle between the sequencing logic, the
// transit driver and the responder FSM.
// master: the transit driver. slave: the command source / responder side.
interface fsm_transit_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_target;
    logic       trans_valid;
    logic [1:0] trans_id;
    logic       trans_ack;
    logic [1:0] cur_state;
    logic       done;
    logic       err;

    modport master (
        input  cmd_valid, cmd_target, trans_ack,
        output cmd_ready, trans_valid, trans_id, cur_state, done, err
    );

    modport slave (
        output cmd_valid, cmd_target, trans_ack,
        input  cmd_ready, trans_valid, trans_id, cur_state, done, err
    );
endinterface

// File: rtl/fsm_transit_driver.sv
// Transit driver: turns a target-state command into one or two transit
// requests towards the responder FSM (sleeping/working/resting), tracks the
// responder state and flags completion or a per-hop ack timeout.
// Optional macro FSM_TRANSIT_DRIVER_STATS_EN adds saturating hop and
// timeout counters as extra outputs.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | ready for a command, cmd_ready high
// S_ISSUE | pick the next hop, raise trans_valid on the following cycle
// S_WAIT  | hold the request until ack or until the timer expires
// S_DONE  | target reached, pulse done on exit
module fsm_transit_driver #(
    parameter int         TIMEOUT    = 16,
    parameter logic [1:0] INIT_STATE = 2'd0
) (
    input  logic clk,
    input  logic rst,
`ifdef FSM_TRANSIT_DRIVER_STATS_EN
    output logic [15:0] hop_count,
    output logic [7:0]  timeout_count,
`endif
    fsm_transit_driver_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       trans_valid_q, trans_valid_nxt;
    logic [1:0] trans_id_q, trans_id_nxt;
    logic [1:0] cur_q, cur_nxt;
    logic [1:0] target_q, target_nxt;
    logic [7:0] timer_q, timer_nxt;
    logic       done_q, done_nxt;
    logic       err_q, err_nxt;

    // Responder state reached after a given transit code.
    function automatic logic [1:0] hop_dest(input logic [1:0] id);
        case (id)
            2'd0:    hop_dest = 2'd1;
            2'd1:    hop_dest = 2'd2;
            default: hop_dest = 2'd0;
        endcase
    endfunction

    // First hop towards tgt; resting->working must pass through sleeping.
    function automatic logic [1:0] next_hop(input logic [1:0] cur, input logic [1:0] tgt);
        case (cur)
            2'd0:    next_hop = 2'd0;
            2'd1:    next_hop = (tgt == 2'd2) ? 2'd1 : 2'd3;
            default: next_hop = 2'd2;
        endcase
    endfunction

    // Register stage: state plus every output, so all outputs are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            trans_valid_q <= 1'b0;
            trans_id_q    <= 2'd0;
            cur_q         <= INIT_STATE;
            target_q      <= INIT_STATE;
            timer_q       <= 8'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            trans_valid_q <= trans_valid_nxt;
            trans_id_q    <= trans_id_nxt;
            cur_q         <= cur_nxt;
            target_q      <= target_nxt;
            timer_q       <= timer_nxt;
            done_q        <= done_nxt;
            err_q         <= err_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt       = state;
        trans_valid_nxt = trans_valid_q;
        trans_id_nxt    = trans_id_q;
        cur_nxt         = cur_q;
        target_nxt      = target_q;
        timer_nxt       = timer_q;
        done_nxt        = 1'b0;
        err_nxt         = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    target_nxt = bus.cmd_target;
                    if (bus.cmd_target == 2'd3) begin
                        err_nxt = 1'b1;
                    end else if (bus.cmd_target == cur_q) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                trans_id_nxt    = next_hop(cur_q, target_q);
                trans_valid_nxt = 1'b1;
                timer_nxt       = 8'd0;
                state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                // ack is checked before the timer so a last-cycle ack still counts
                if (bus.trans_ack) begin
                    trans_valid_nxt = 1'b0;
                    cur_nxt         = hop_dest(trans_id_q);
                    state_nxt       = (hop_dest(trans_id_q) == target_q) ? S_DONE : S_ISSUE;
                end else if (timer_q == TIMER_LAST) begin
                    trans_valid_nxt = 1'b0;
                    err_nxt         = 1'b1;
                    timer_nxt       = 8'd0;
                    state_nxt       = S_IDLE;
                end else begin
                    timer_nxt = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state == S_IDLE);
    assign bus.trans_valid = trans_valid_q;
    assign bus.trans_id    = trans_id_q;
    assign bus.cur_state   = cur_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

`ifdef FSM_TRANSIT_DRIVER_STATS_EN
    logic hop_acked;
    logic hop_timed_out;

    assign hop_acked     = (state == S_WAIT) && bus.trans_ack;
    assign hop_timed_out = (state == S_WAIT) && !bus.trans_ack && (timer_q == TIMER_LAST);

    // Saturating counters of acked hops and timeout errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            hop_count     <= 16'd0;
            timeout_count <= 8'd0;
        end else begin
            if (hop_acked && (hop_count != 16'hffff))
                hop_count <= hop_count + 16'd1;
            if (hop_timed_out && (timeout_count != 8'hff))
                timeout_count <= timeout_count + 8'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fsm_transit_driver.sv
// Bench for fsm_transit_driver: a table of commands applied in sequence,
// expected transit codes queued per command and popped as hops appear,
// plus hand-written reset, idle-ack and busy-command sequences.
module tb_fsm_transit_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsm_transit_driver_if bus();

`ifdef FSM_TRANSIT_DRIVER_STATS_EN
    logic [15:0] hop_count;
    logic [7:0]  timeout_count;
`endif

    fsm_transit_driver #(.TIMEOUT(16), .INIT_STATE(2'd0)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FSM_TRANSIT_DRIVER_STATS_EN
        .hop_count     (hop_count),
        .timeout_count (timeout_count),
`endif
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] tgt;
        int         ack_delay;   // extra valid cycles before ack; -1 = never ack
        bit         exp_done;
        bit         exp_err;
        int         exp_cyc;     // cycle of done/err pulse, accept cycle = 0
        logic [1:0] exp_cur;
        int         exp_hops;
        int         exp_valid;   // total cycles with trans_valid high
    } vec_t;

    vec_t       vecs[10];
    logic [1:0] exp_q[$];
    logic [1:0] model_cur;
    int         model_acked;
    int         model_timeouts;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected hop codes for a command, from the routing table.
    function automatic void push_hops(input logic [1:0] cur, input logic [1:0] tgt);
        if (tgt == 2'd3 || tgt == cur) return;
        case (cur)
            2'd0: begin
                exp_q.push_back(2'd0);
                if (tgt == 2'd2) exp_q.push_back(2'd1);
            end
            2'd1: exp_q.push_back((tgt == 2'd2) ? 2'd1 : 2'd3);
            default: begin
                exp_q.push_back(2'd2);
                if (tgt == 2'd1) exp_q.push_back(2'd0);
            end
        endcase
    endfunction

    task automatic run_cmd(input vec_t v);
        int cyc = 1;
        int streak = 0;
        int hops = 0;
        int vcnt = 0;
        bit seen_done = 0;
        bit seen_err = 0;
        bit unstable = 0;
        logic [1:0] held = 2'd0;
        logic [1:0] e;
        push_hops(model_cur, v.tgt);
        check("cmd_ready_idle", int'(bus.cmd_ready), 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = v.tgt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (cyc <= 100 && !(seen_done || seen_err)) begin
            if (bus.trans_valid) begin
                if (streak == 0) begin
                    hops++;
                    held = bus.trans_id;
                    if (exp_q.size() == 0) begin
                        check("unexpected_hop", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("trans_id", int'(bus.trans_id), int'(e));
                    end
                end else if (bus.trans_id != held) begin
                    unstable = 1;
                end
                streak++;
                vcnt++;
                bus.trans_ack = (v.ack_delay >= 0 && streak == v.ack_delay + 1);
            end else begin
                streak = 0;
                bus.trans_ack = 1'b0;
            end
            if (bus.done) seen_done = 1;
            if (bus.err)  seen_err  = 1;
            if (!(seen_done || seen_err)) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.trans_ack = 1'b0;
        if (!(seen_done || seen_err))
            $display("FAIL cmd_bound: got no done/err within %0d cycles, expected a pulse", cyc);
        check("done_seen", int'(seen_done), int'(v.exp_done));
        check("err_seen", int'(seen_err), int'(v.exp_err));
        check("latency", cyc, v.exp_cyc);
        check("cur_state", int'(bus.cur_state), int'(v.exp_cur));
        check("hops", hops, v.exp_hops);
        check("valid_cycles", vcnt, v.exp_valid);
        check("id_stable", int'(unstable), 0);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("pulse_len", int'(bus.done | bus.err), 0);
        check("cmd_ready_after", int'(bus.cmd_ready), 1);
        model_cur = v.exp_cur;
        if (v.exp_done) model_acked += v.exp_hops;
        if (v.exp_err && v.tgt != 2'd3) model_timeouts++;
    endtask

    initial begin
        // tgt  dly done err cyc cur hops valid
        vecs[0] = '{2'd1,  0, 1'b1, 1'b0,  4, 2'd1, 1,  1}; // sleeping->working
        vecs[1] = '{2'd2,  5, 1'b1, 1'b0,  9, 2'd2, 1,  6}; // working->resting, late ack
        vecs[2] = '{2'd1,  0, 1'b1, 1'b0,  6, 2'd1, 2,  2}; // resting->working, two hops
        vecs[3] = '{2'd0, -1, 1'b0, 1'b1, 18, 2'd1, 1, 16}; // timeout, state unchanged
        vecs[4] = '{2'd3,  0, 1'b0, 1'b1,  1, 2'd1, 0,  0}; // illegal target
        vecs[5] = '{2'd1,  0, 1'b1, 1'b0,  1, 2'd1, 0,  0}; // already there
        vecs[6] = '{2'd0,  2, 1'b1, 1'b0,  6, 2'd0, 1,  3}; // working->sleeping
        vecs[7] = '{2'd2,  0, 1'b1, 1'b0,  6, 2'd2, 2,  2}; // sleeping->resting, two hops
        vecs[8] = '{2'd0, 15, 1'b1, 1'b0, 19, 2'd0, 1, 16}; // ack on the limit cycle wins
        vecs[9] = '{2'd1,  0, 1'b1, 1'b0,  4, 2'd1, 1,  1};

        bus.cmd_valid  = 1'b0;
        bus.cmd_target = 2'd0;
        bus.trans_ack  = 1'b0;
        model_cur      = 2'd0;
        model_acked    = 0;
        model_timeouts = 0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 1);
        check("rst_trans_valid", int'(bus.trans_valid), 0);
        check("rst_trans_id", int'(bus.trans_id), 0);
        check("rst_cur_state", int'(bus.cur_state), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
`ifdef FSM_TRANSIT_DRIVER_STATS_EN
        check("rst_hop_count", int'(hop_count), 0);
        check("rst_timeout_count", int'(timeout_count), 0);
`endif
        rst = 1'b0;

        // stray ack with no request outstanding
        bus.trans_ack = 1'b1;
        @(negedge clk);
        bus.trans_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_cur", int'(bus.cur_state), 0);
        check("idle_ack_valid", int'(bus.trans_valid), 0);
        check("idle_ack_done", int'(bus.done | bus.err), 0);

        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

`ifdef FSM_TRANSIT_DRIVER_STATS_EN
        check("hop_count_total", int'(hop_count), model_acked);
        check("timeout_count_total", int'(timeout_count), model_timeouts);
`endif

        // reset while waiting for ack; a busy-time command must not be queued
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 2'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_valid", int'(bus.trans_valid), 1);
        check("wait_id", int'(bus.trans_id), 1);
        check("busy_cmd_ready", int'(bus.cmd_ready), 0);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 2'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", int'(bus.trans_valid), 0);
        check("midrst_cur", int'(bus.cur_state), 0);
        check("midrst_ready", int'(bus.cmd_ready), 1);
`ifdef FSM_TRANSIT_DRIVER_STATS_EN
        check("midrst_hop_count", int'(hop_count), 0);
        check("midrst_timeout_count", int'(timeout_count), 0);
`endif
        rst = 1'b0;
        model_cur = 2'd0;
        repeat (4) @(negedge clk);
        check("no_queued_valid", int'(bus.trans_valid), 0);
        check("no_queued_pulse", int'(bus.done | bus.err), 0);

        run_cmd(vecs[7]);
`ifdef FSM_TRANSIT_DRIVER_STATS_EN
        check("two_hop_count", int'(hop_count), 2);
        check("two_hop_timeouts", int'(timeout_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
